// File: rtl/debug_phy_shift.sv
// debug_phy_shift: strobe-driven serial shift engine for the debug PHY.
// Drives SCK/SDO/SDO_OE LSB-first from WDATA and captures SDI on each rising strobe.
module debug_phy_shift #(
    parameter  int WIDTH = 32,
    localparam int LW    = $clog2(WIDTH) + 1
) (
    input  logic             i_clkin,
    input  logic             i_resetn,
    input  logic             i_rise_stb,
    input  logic             i_fall_stb,
    input  logic             i_start,
    input  logic [LW-1:0]    i_len,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_oe_req,
    input  logic             i_sdi,
    output logic             o_sck,
    output logic             o_sdo,
    output logic             o_sdo_oe,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_rdata
);
    typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_tx;
    logic [WIDTH-1:0] r_rx;
    logic [LW-1:0]    r_len;
    logic [LW-1:0]    r_cnt;
    logic             r_sck;
    logic             r_sdo;
    logic             r_oe;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_rdata;

    // Coincident strobes are an upstream fault and are treated as neither.
    logic          w_rise;
    logic          w_fall;
    logic [LW-1:0] w_len;
    logic [LW-1:0] w_shamt;

    assign w_rise  = i_rise_stb & ~i_fall_stb;
    assign w_fall  = i_fall_stb & ~i_rise_stb;
    assign w_len   = (i_len == '0) ? LW'(WIDTH) : i_len;
    assign w_shamt = LW'(WIDTH) - r_len;

    always_ff @(posedge i_clkin or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state <= IDLE;
            r_tx    <= '0;
            r_rx    <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_sck   <= 1'b0;
            r_sdo   <= 1'b0;
            r_oe    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (i_start) begin
                    r_tx    <= i_wdata;
                    r_len   <= w_len;
                    r_cnt   <= '0;
                    r_rx    <= '0;
                    r_sdo   <= i_wdata[0];
                    r_oe    <= i_oe_req;
                    r_busy  <= 1'b1;
                    r_state <= LOW;
                end
                LOW: if (w_rise) begin
                    r_sck   <= 1'b1;
                    r_rx    <= {i_sdi, r_rx[WIDTH-1:1]};
                    r_cnt   <= r_cnt + 1'b1;
                    r_state <= HIGH;
                end
                HIGH: if (w_fall) begin
                    r_sck <= 1'b0;
                    if (r_cnt == r_len) begin
                        // Captured bits sit at the top of rx; shift them down to bit 0.
                        r_rdata <= r_rx >> w_shamt;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_oe    <= 1'b0;
                        r_sdo   <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_tx    <= r_tx >> 1;
                        r_sdo   <= r_tx[1];
                        r_state <= LOW;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_sck    = r_sck;
    assign o_sdo    = r_sdo;
    assign o_sdo_oe = r_oe;
    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_rdata  = r_rdata;
endmodule

// File: tb/tb_debug_phy_shift.sv
// tb_debug_phy_shift: table-driven and randomized checks of debug_phy_shift
// against a bit-level transaction model.
module tb_debug_phy_shift;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        rise = 1'b0, fall = 1'b0, start = 1'b0, oe_req = 1'b0, sdi = 1'b0;
    logic [5:0]  len = '0;
    logic [31:0] wdata = '0;
    logic        sck, sdo, sdo_oe, busy, done;
    logic [31:0] rdata;
    int          checks = 0, errors = 0;

    debug_phy_shift #(.WIDTH(32)) dut (
        .i_clkin(clk), .i_resetn(resetn), .i_rise_stb(rise), .i_fall_stb(fall),
        .i_start(start), .i_len(len), .i_wdata(wdata), .i_oe_req(oe_req), .i_sdi(sdi),
        .o_sck(sck), .o_sdo(sdo), .o_sdo_oe(sdo_oe), .o_busy(busy), .o_done(done),
        .o_rdata(rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          n;
        logic [31:0] wd;
        logic        oe;
        logic [31:0] sd;
        int          gap;
        logic [31:0] exp;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: the bits received, right-justified, with everything above the length cleared.
    function automatic logic [31:0] model_rdata(input int n, input logic [31:0] sd);
        int          l = (n == 0) ? 32 : n;
        logic [31:0] r = '0;
        for (int b = 0; b < l; b++) r[b] = sd[b];
        return r;
    endfunction

    task automatic wait_cycles(input int k, input logic exp_sck, input logic oe);
        for (int i = 0; i < k; i++) begin
            start = 1'b1;
            tick();
            chk("hold_sck", sck, exp_sck);
            chk("hold_busy", busy, 1);
            chk("hold_oe", sdo_oe, oe);
            chk("hold_done", done, 0);
        end
        start = 1'b0;
    endtask

    // Starts a transaction in the current cycle; returns positioned in the DONE cycle.
    task automatic txn(input int n, input logic [31:0] wd, input logic oe, input logic [31:0] sd,
                       input int gap, input logic [31:0] exp, input logic sim);
        int l = (n == 0) ? 32 : n;
        start = 1'b1; wdata = wd; len = 6'(n); oe_req = oe;
        tick();
        start = 1'b0;
        chk("accept_busy", busy, 1);
        chk("accept_sdo", sdo, wd[0]);
        chk("accept_oe", sdo_oe, oe);
        wdata = ~wd; len = 6'($urandom_range(1, 32)); oe_req = ~oe;
        for (int b = 0; b < l; b++) begin
            wait_cycles(gap - 1, 1'b0, oe);
            if (sim) begin
                rise = 1'b1; fall = 1'b1; sdi = ~sd[b];
                tick();
                chk("sim_low_sck", sck, 0);
            end
            rise = 1'b1; fall = 1'b0; sdi = sd[b];
            tick();
            rise = 1'b0; sdi = $urandom;
            chk("rise_sck", sck, 1);
            chk("rise_sdo", sdo, wd[b]);
            chk("rise_oe", sdo_oe, oe);
            wait_cycles(gap - 1, 1'b1, oe);
            if (sim) begin
                rise = 1'b1; fall = 1'b1;
                tick();
                chk("sim_high_sck", sck, 1);
                chk("sim_high_sdo", sdo, wd[b]);
            end
            rise = 1'b0; fall = 1'b1;
            tick();
            fall = 1'b0;
            chk("fall_sck", sck, 0);
            if (b < l - 1) begin
                chk("next_sdo", sdo, wd[b+1]);
                chk("next_busy", busy, 1);
                chk("next_done", done, 0);
            end else begin
                chk("done_pulse", done, 1);
                chk("done_busy", busy, 0);
                chk("done_oe", sdo_oe, 0);
                chk("done_sdo", sdo, 0);
                chk("rdata", rdata, exp);
            end
        end
    endtask

    task automatic finish_idle(input logic [31:0] exp);
        tick();
        chk("done_one_cycle", done, 0);
        chk("idle_busy", busy, 0);
        chk("rdata_hold", rdata, exp);
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{8,  32'h000000A5, 1'b1, 32'h0000005A, 4, 32'h0000005A};
        vecs[1] = '{0,  32'h12345678, 1'b0, 32'hDEADBEEF, 2, 32'hDEADBEEF};
        vecs[2] = '{3,  32'h00000000, 1'b0, 32'hFFFFFFF3, 1, 32'h00000003};
        vecs[3] = '{1,  32'h00000001, 1'b1, 32'h00000001, 1, 32'h00000001};
        vecs[4] = '{32, 32'hFFFFFFFF, 1'b1, 32'h80000001, 1, 32'h80000001};
        vecs[5] = '{5,  32'h0000001F, 1'b1, 32'hFFFFFFFF, 2, 32'h0000001F};

        // Reset and idle strobes
        #2;
        chk("rst_sck", sck, 0); chk("rst_sdo", sdo, 0); chk("rst_oe", sdo_oe, 0);
        chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_rdata", rdata, 0);
        tick(); tick();
        resetn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rise = i[0]; fall = ~i[0];
            tick();
            chk("idle_sck", sck, 0);
            chk("idle_busy", busy, 0);
        end
        rise = 1'b0; fall = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            txn(vecs[i].n, vecs[i].wd, vecs[i].oe, vecs[i].sd, vecs[i].gap, vecs[i].exp, 1'b0);
            finish_idle(vecs[i].exp);
        end

        // Back-to-back: second START lands in the DONE cycle; strobe collisions mixed in
        txn(4, 32'h9, 1'b1, 32'h6, 1, 32'h6, 1'b1);
        txn(6, 32'h2A, 1'b0, 32'h15, 2, 32'h15, 1'b1);
        finish_idle(32'h15);

        // Reset mid-transfer of a 16-bit write, during the high phase of bit 5
        start = 1'b1; wdata = 32'hFFFF; len = 6'd16; oe_req = 1'b1;
        tick();
        start = 1'b0;
        for (int b = 0; b < 6; b++) begin
            rise = 1'b1; tick(); rise = 1'b0;
            if (b < 5) begin fall = 1'b1; tick(); fall = 1'b0; end
        end
        chk("pre_rst_sck", sck, 1);
        #2 resetn = 1'b0;
        #1;
        chk("async_sck", sck, 0); chk("async_sdo", sdo, 0); chk("async_oe", sdo_oe, 0);
        chk("async_busy", busy, 0); chk("async_rdata", rdata, 0);
        for (int i = 0; i < 3; i++) begin
            fall = 1'b1;
            tick();
            chk("rst_no_done", done, 0);
        end
        fall = 1'b0;
        resetn = 1'b1;
        tick();
        txn(2, 32'h2, 1'b1, 32'h1, 1, 32'h1, 1'b0);
        finish_idle(32'h1);

        // Randomized transactions against the model
        for (int k = 0; k < 24; k++) begin
            int          n  = $urandom_range(0, 32);
            logic [31:0] wd = $urandom;
            logic [31:0] sd = $urandom;
            logic        oe = 1'($urandom);
            txn(n, wd, oe, sd, $urandom_range(1, 3), model_rdata(n, sd), 1'($urandom));
            if ($urandom_range(0, 1) == 0) finish_idle(model_rdata(n, sd));
        end
        finish_idle(rdata === rdata ? rdata : 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
